// File: rtl/exec_arb_pkg.sv
// Shared widths and record types for the execute-unit issue arbiter.
// The issue record mirrors the execute unit's input bundle; the tag follows each issue through the pipe.
package exec_arb_pkg;

   localparam int WORD_SIZE  = 32;
   localparam int REG_ADDR_W = 5;
   localparam int FUNCT7_W   = 7;
   localparam int FUNCT3_W   = 3;
   localparam int TAG_ID_W   = 4;   // requester IDs up to 16 requesters

   typedef struct packed {
      logic [WORD_SIZE-1:0]  src1;
      logic [WORD_SIZE-1:0]  src2;
      logic [FUNCT7_W-1:0]   funct7;
      logic [FUNCT3_W-1:0]   funct3;
      logic [REG_ADDR_W-1:0] rd;
      logic                  we;
   } issue_t;

   localparam issue_t BUBBLE = '0;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: first asserted request at or after ptr, wrapping modulo N.
// Purely combinational; the caller owns the pointer.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   logic [IW-1:0] idx;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!any && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/exec_issue_arbiter.sv
// Shares one execute unit among NUM_REQ issue requesters, one grant per cycle in round-robin order,
// and tags each result on its way back with the ID of the requester that issued it.
module exec_issue_arbiter #(
   parameter int WORD_SIZE   = 32,
   parameter int NUM_REQ     = 2,
   parameter int EXE_LATENCY = 2,
   parameter int ID_W        = $clog2(NUM_REQ)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         stall,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*WORD_SIZE-1:0] req_src1,
   input  logic [NUM_REQ*WORD_SIZE-1:0] req_src2,
   input  logic [NUM_REQ*7-1:0]         req_funct7,
   input  logic [NUM_REQ*3-1:0]         req_funct3,
   input  logic [NUM_REQ*5-1:0]         req_rd,
   input  logic [NUM_REQ-1:0]           req_we,
   output logic [WORD_SIZE-1:0]         exe_src1,
   output logic [WORD_SIZE-1:0]         exe_src2,
   output logic [6:0]                   exe_funct7,
   output logic [2:0]                   exe_funct3,
   output logic [4:0]                   exe_rd,
   output logic                         exe_we,
   input  logic [WORD_SIZE-1:0]         exe_data_in,
   input  logic [4:0]                   exe_rd_in,
   input  logic                         exe_we_in,
   output logic                         resp_valid,
   output logic [ID_W-1:0]              resp_id,
   output logic [WORD_SIZE-1:0]         resp_data,
   output logic [4:0]                   resp_rd,
   output logic                         resp_we
);

   import exec_arb_pkg::*;

   logic [ID_W-1:0]    ptr;
   logic [NUM_REQ-1:0] arb_req;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic               grant_any;
   issue_t             issue_d;
   issue_t             issue_q;
   tag_t               tag_q [EXE_LATENCY];
   tag_t               tag_last;

   // Held in reset or stalled, nobody is offered the execute unit.
   assign arb_req = req_valid & {NUM_REQ{~stall & ~reset}};

   rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_rr (
      .req       (arb_req),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (grant_any)
   );

   assign req_ready = grant;

   always_comb begin
      issue_d = BUBBLE;
      if (grant_any) begin
         issue_d.src1   = req_src1[grant_idx*WORD_SIZE +: WORD_SIZE];
         issue_d.src2   = req_src2[grant_idx*WORD_SIZE +: WORD_SIZE];
         issue_d.funct7 = req_funct7[grant_idx*FUNCT7_W +: FUNCT7_W];
         issue_d.funct3 = req_funct3[grant_idx*FUNCT3_W +: FUNCT3_W];
         issue_d.rd     = req_rd[grant_idx*REG_ADDR_W +: REG_ADDR_W];
         issue_d.we     = req_we[grant_idx];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr     <= '0;
         issue_q <= BUBBLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
         issue_q <= issue_d;
         if (grant_any)
            ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Tag pipe runs in lockstep with the execute latency and is never stalled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: this small array is reset on purpose: stale tags would raise resp_valid for dropped issues.
         for (int i = 0; i < EXE_LATENCY; i++)
            tag_q[i] <= '0;
      end else begin
         tag_q[0] <= '{valid: grant_any, id: TAG_ID_W'(grant_idx)};
         for (int i = 1; i < EXE_LATENCY; i++)
            tag_q[i] <= tag_q[i-1];
      end
   end

   assign exe_src1   = issue_q.src1;
   assign exe_src2   = issue_q.src2;
   assign exe_funct7 = issue_q.funct7;
   assign exe_funct3 = issue_q.funct3;
   assign exe_rd     = issue_q.rd;
   assign exe_we     = issue_q.we;

   assign tag_last   = tag_q[EXE_LATENCY-1];
   assign resp_valid = tag_last.valid;
   assign resp_id    = tag_last.id[ID_W-1:0];
   assign resp_data  = exe_data_in;
   assign resp_rd    = exe_rd_in;
   // The execute unit is not reset, so its write enable is only trusted alongside a live tag.
   assign resp_we    = exe_we_in & tag_last.valid;

endmodule

// File: tb/tb_exec_issue_arbiter.sv
// Directed bench for exec_issue_arbiter with a one-register add/sub execute model behind it.
module tb_exec_issue_arbiter;

   localparam int W = 32;
   localparam int N = 2;

   logic           clock = 1'b0;
   logic           reset;
   logic           stall;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_src1;
   logic [N*W-1:0] req_src2;
   logic [N*7-1:0] req_funct7;
   logic [N*3-1:0] req_funct3;
   logic [N*5-1:0] req_rd;
   logic [N-1:0]   req_we;
   logic [W-1:0]   exe_src1;
   logic [W-1:0]   exe_src2;
   logic [6:0]     exe_funct7;
   logic [2:0]     exe_funct3;
   logic [4:0]     exe_rd;
   logic           exe_we;
   logic [W-1:0]   exe_data_in;
   logic [4:0]     exe_rd_in;
   logic           exe_we_in;
   logic           resp_valid;
   logic [0:0]     resp_id;
   logic [W-1:0]   resp_data;
   logic [4:0]     resp_rd;
   logic           resp_we;

   int n_checks = 0;
   int n_fail   = 0;

   exec_issue_arbiter #(.WORD_SIZE(W), .NUM_REQ(N), .EXE_LATENCY(2)) dut (
      .clock       (clock),
      .reset       (reset),
      .stall       (stall),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_src1    (req_src1),
      .req_src2    (req_src2),
      .req_funct7  (req_funct7),
      .req_funct3  (req_funct3),
      .req_rd      (req_rd),
      .req_we      (req_we),
      .exe_src1    (exe_src1),
      .exe_src2    (exe_src2),
      .exe_funct7  (exe_funct7),
      .exe_funct3  (exe_funct3),
      .exe_rd      (exe_rd),
      .exe_we      (exe_we),
      .exe_data_in (exe_data_in),
      .exe_rd_in   (exe_rd_in),
      .exe_we_in   (exe_we_in),
      .resp_valid  (resp_valid),
      .resp_id     (resp_id),
      .resp_data   (resp_data),
      .resp_rd     (resp_rd),
      .resp_we     (resp_we)
   );

   always #5 clock = ~clock;

   // Unreset execute stand-in: result visible one edge after exe_* change, sampled at the next edge.
   always @(posedge clock) begin
      exe_data_in <= (exe_funct7 == 7'h20) ? exe_src1 - exe_src2 : exe_src1 + exe_src2;
      exe_rd_in   <= exe_rd;
      exe_we_in   <= exe_we;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd, input logic we);
      req_valid[i]         = v;
      req_src1[i*W +: W]   = s1;
      req_src2[i*W +: W]   = s2;
      req_funct7[i*7 +: 7] = f7;
      req_funct3[i*3 +: 3] = f3;
      req_rd[i*5 +: 5]     = rd;
      req_we[i]            = we;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0;
      req_valid = '0; req_src1 = '0; req_src2 = '0;
      req_funct7 = '0; req_funct3 = '0; req_rd = '0; req_we = '0;
      tick(); tick();
      check("rst_exe_we", exe_we, 0);
      check("rst_exe_src1", exe_src1, 0);
      check("rst_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_id", resp_id, 0);

      // Async reset mid-cycle clears the issue register and blocks the grant at once.
      reset = 1'b0;
      set_req(0, 1, 1, 1, 0, 0, 1, 1);
      #1 check("t1_ready", req_ready, 2'b01);
      tick();
      check("t1_exe_we", exe_we, 1);
      #1 reset = 1'b1;
      #1;
      check("t1_async_exe_we", exe_we, 0);
      check("t1_async_ready", req_ready, 0);
      check("t1_async_resp_valid", resp_valid, 0);
      set_req(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      reset = 1'b0;

      // Single add from requester 0.
      set_req(0, 1, 5, 7, 0, 0, 3, 1);
      #1 check("t2_ready", req_ready, 2'b01);
      tick();
      set_req(0, 0, 0, 0, 0, 0, 0, 0);
      check("t2_exe_src1", exe_src1, 5);
      check("t2_exe_src2", exe_src2, 7);
      check("t2_exe_rd", exe_rd, 3);
      check("t2_exe_we", exe_we, 1);
      check("t2_early_resp", resp_valid, 0);
      tick();
      check("t2_resp_valid", resp_valid, 1);
      check("t2_resp_id", resp_id, 0);
      check("t2_resp_data", resp_data, 12);
      check("t2_resp_rd", resp_rd, 3);
      check("t2_resp_we", resp_we, 1);
      tick();
      check("t2_resp_gone", resp_valid, 0);
      check("t2_bubble_we", exe_we, 0);

      // Requester 1 alone (ptr=1): subtract with we=0, brings ptr back to 0.
      set_req(1, 1, 10, 3, 7'h20, 0, 4, 0);
      #1 check("r1_ready", req_ready, 2'b10);
      tick();
      set_req(1, 0, 0, 0, 0, 0, 0, 0);
      check("r1_exe_funct7", exe_funct7, 7'h20);
      tick();
      check("r1_resp_valid", resp_valid, 1);
      check("r1_resp_id", resp_id, 1);
      check("r1_resp_data", resp_data, 7);
      check("r1_resp_rd", resp_rd, 4);
      check("r1_resp_we", resp_we, 0);

      // Both requesters for four cycles: alternate 0,1,0,1 with back-to-back responses.
      set_req(0, 1, 100, 1, 0, 0, 1, 1);
      set_req(1, 1, 200, 2, 0, 0, 2, 1);
      for (int k = 0; k < 4; k++) begin
         #1 check("t3_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
         tick();
         check("t3_exe_rd", exe_rd, (k % 2 == 0) ? 1 : 2);
         if (k > 0) begin
            check("t3_resp_valid", resp_valid, 1);
            check("t3_resp_id", resp_id, (k - 1) % 2);
            check("t3_resp_data", resp_data, ((k - 1) % 2 == 0) ? 101 : 202);
         end
      end
      req_valid = '0;
      #1 check("t3_idle_ready", req_ready, 2'b00);
      tick();
      check("t3_last_resp_id", resp_id, 1);
      check("t3_last_resp_data", resp_data, 202);
      tick();
      check("t3_drained", resp_valid, 0);

      // Stall two cycles right after an issue: no grants, in-flight result still returns.
      req_valid = 2'b11;
      #1 check("t4_ready", req_ready, 2'b01);
      tick();
      stall = 1'b1;
      #1 check("t4_stall_ready", req_ready, 2'b00);
      tick();
      check("t4_stall_exe_we", exe_we, 0);
      check("t4_drain_valid", resp_valid, 1);
      check("t4_drain_id", resp_id, 0);
      check("t4_drain_data", resp_data, 101);
      check("t4_stall_ready2", req_ready, 2'b00);
      tick();
      check("t4_stall_exe_we2", exe_we, 0);
      check("t4_stall_no_resp", resp_valid, 0);
      stall = 1'b0;
      #1 check("t4_resume_ready", req_ready, 2'b10);
      tick();
      check("t4_resume_exe_rd", exe_rd, 2);
      req_valid = '0;
      tick();
      check("t4_resume_resp_id", resp_id, 1);
      check("t4_resume_resp_data", resp_data, 202);

      // Three issues, then reset with results in flight: all dropped, stale exe_we_in masked.
      req_valid = 2'b11;
      tick(); tick(); tick();
      req_valid = '0;
      check("t5_inflight", resp_valid, 1);
      #1 reset = 1'b1;
      #1;
      check("t5_rst_resp_valid", resp_valid, 0);
      check("t5_rst_resp_we", resp_we, 0);
      check("t5_rst_exe_we", exe_we, 0);
      tick();
      reset = 1'b0;
      tick();
      check("t5_no_resp_1", resp_valid, 0);
      tick();
      check("t5_no_resp_2", resp_valid, 0);
      req_valid = 2'b11;
      #1 check("t5_ptr_reset_ready", req_ready, 2'b01);
      tick();
      req_valid = '0;
      tick();
      check("t5_new_resp_valid", resp_valid, 1);
      check("t5_new_resp_id", resp_id, 0);
      check("t5_new_resp_data", resp_data, 101);

      // Idle cycles: pure bubbles, pointer held at 1.
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t6_exe_we", exe_we, 0);
         check("t6_exe_src1", exe_src1, 0);
         check("t6_exe_src2", exe_src2, 0);
         check("t6_exe_funct7", exe_funct7, 0);
         check("t6_exe_funct3", exe_funct3, 0);
         check("t6_exe_rd", exe_rd, 0);
         check("t6_resp_valid", resp_valid, 0);
      end
      req_valid = 2'b11;
      #1 check("t6_ptr_held_ready", req_ready, 2'b10);
      req_valid = 2'b01;
      #1 check("t6_single_req_ready", req_ready, 2'b01);
      req_valid = '0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected end of sequence");
      $fatal(1, "watchdog");
   end

endmodule
